// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if
//   Bundles the processor-side issue/write-back signals and the FPU-side
//   enable/operand/result signals of the float issue sequencer.
//   slave  : view used by the sequencer (fpu_issue_ctrl)
//   master : view used by whatever surrounds it (processor + FPU, or a bench)
interface fpu_issue_ctrl_if;
   // processor -> sequencer
   logic        issue;
   logic [4:0]  opcode;
   logic [3:0]  dest;
   logic [15:0] a_val;
   logic [15:0] b_val;
   // sequencer -> processor
   logic        busy;
   logic        illegal;
   logic        wb_en;
   logic [3:0]  wb_reg;
   logic [15:0] wb_data;
   logic        err;
   // sequencer <-> FPU
   logic        fpu_en;
   logic [4:0]  fpu_instr;
   logic [15:0] fpu_op1;
   logic [15:0] fpu_op2;
   logic        fpu_done;
   logic [15:0] fpu_result;

   modport slave (
      input  issue, opcode, dest, a_val, b_val, fpu_done, fpu_result,
      output busy, illegal, fpu_en, fpu_instr, fpu_op1, fpu_op2,
             wb_en, wb_reg, wb_data, err
   );

   modport master (
      output issue, opcode, dest, a_val, b_val, fpu_done, fpu_result,
      input  busy, illegal, fpu_en, fpu_instr, fpu_op1, fpu_op2,
             wb_en, wb_reg, wb_data, err
   );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Captures one float instruction from execute, drives the FPU, waits for a
//   fresh done (or times out) and returns the result as a one-cycle register
//   write. SUBF is issued to the FPU as ADDF with op2's sign flipped.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fpu_issue_ctrl_if.slave (issue/opcode/dest/a_val/b_val in,
//                busy/illegal out, fpu_* to/from FPU, wb_*/err write-back)
// Parameters:
//   TIMEOUT    : WAIT cycles allowed before the op is aborted with err (>=2)
module fpu_issue_ctrl #(
   parameter int TIMEOUT = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   fpu_issue_ctrl_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT) + 1;

   localparam logic [4:0] OP_ADDF = 5'h11;
   localparam logic [4:0] OP_SUBF = 5'h16;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_WB} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fpu_en_q, fpu_en_d;
   logic [4:0]    fpu_instr_q, fpu_instr_d;
   logic [15:0]   fpu_op1_q, fpu_op1_d;
   logic [15:0]   fpu_op2_q, fpu_op2_d;
   logic [3:0]    wb_reg_q, wb_reg_d;
   logic [15:0]   wb_data_q, wb_data_d;
   logic          wb_en_q, wb_en_d;
   logic          err_q, err_d;
   logic          illegal_q, illegal_d;
   logic          legal;

   always_comb legal = (bus.opcode >= OP_ADDF) && (bus.opcode <= OP_SUBF);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fpu_en_d    = fpu_en_q;
      fpu_instr_d = fpu_instr_q;
      fpu_op1_d   = fpu_op1_q;
      fpu_op2_d   = fpu_op2_q;
      wb_reg_d    = wb_reg_q;
      wb_data_d   = wb_data_q;
      wb_en_d     = 1'b0;
      err_d       = 1'b0;
      illegal_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.issue) begin
               if (legal) begin
                  fpu_op1_d = bus.a_val;
                  wb_reg_d  = bus.dest;
                  fpu_en_d  = 1'b1;
                  state_d   = S_ARM;
                  if (bus.opcode == OP_SUBF) begin
                     fpu_instr_d = OP_ADDF;
                     fpu_op2_d   = {~bus.b_val[15], bus.b_val[14:0]};
                  end else begin
                     fpu_instr_d = bus.opcode;
                     fpu_op2_d   = bus.b_val;
                  end
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         // done is not looked at here: it may still be high from the last op
         S_ARM: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         // done takes priority over the timeout on the same edge
         S_WAIT: begin
            if (bus.fpu_done) begin
               wb_data_d = bus.fpu_result;
               wb_en_d   = 1'b1;
               fpu_en_d  = 1'b0;
               state_d   = S_WB;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               wb_data_d = '0;
               wb_en_d   = 1'b1;
               err_d     = 1'b1;
               fpu_en_d  = 1'b0;
               state_d   = S_WB;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         fpu_en_q    <= 1'b0;
         fpu_instr_q <= '0;
         fpu_op1_q   <= '0;
         fpu_op2_q   <= '0;
         wb_reg_q    <= '0;
         wb_data_q   <= '0;
         wb_en_q     <= 1'b0;
         err_q       <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fpu_en_q    <= fpu_en_d;
         fpu_instr_q <= fpu_instr_d;
         fpu_op1_q   <= fpu_op1_d;
         fpu_op2_q   <= fpu_op2_d;
         wb_reg_q    <= wb_reg_d;
         wb_data_q   <= wb_data_d;
         wb_en_q     <= wb_en_d;
         err_q       <= err_d;
         illegal_q   <= illegal_d;
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.illegal   = illegal_q;
   assign bus.fpu_en    = fpu_en_q;
   assign bus.fpu_instr = fpu_instr_q;
   assign bus.fpu_op1   = fpu_op1_q;
   assign bus.fpu_op2   = fpu_op2_q;
   assign bus.wb_en     = wb_en_q;
   assign bus.wb_reg    = wb_reg_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios with literal expectations plus
// randomized issue traffic against a behavioural FPU, all checked every cycle
// against a transaction-level model (edges since acceptance).
module tb_fpu_issue_ctrl;
   localparam int T = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fpu_issue_ctrl_if bus ();
   fpu_issue_ctrl #(.TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   // FPU source select: manual (directed) or behavioural (random)
   logic        use_auto = 1'b0;
   logic        man_done = 1'b0, auto_done = 1'b0;
   logic [15:0] man_res = '0, auto_res = '0;
   assign bus.fpu_done   = use_auto ? auto_done : man_done;
   assign bus.fpu_result = use_auto ? auto_res  : man_res;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // An accepted op is tracked by its age in edges since acceptance:
   // age 1 is ARM, done is honoured from age 2, timeout lands at age T+1,
   // and the write-back cycle follows, then the op retires.
   bit          m_active, m_wbphase, m_en, m_wb, m_err, m_ill;
   int          m_age;
   logic [4:0]  m_instr;
   logic [15:0] m_op1, m_op2, m_wbdata;
   logic [3:0]  m_reg;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 0; m_wbphase = 0; m_en = 0; m_wb = 0; m_err = 0; m_ill = 0;
         m_age = 0; m_instr = '0; m_op1 = '0; m_op2 = '0; m_wbdata = '0; m_reg = '0;
      end else begin
         m_wb = 0; m_err = 0; m_ill = 0;
         if (m_active) begin
            if (m_wbphase) begin
               m_active = 0; m_wbphase = 0;
            end else begin
               m_age++;
               if (m_age >= 2 && bus.fpu_done) begin
                  m_wbdata = bus.fpu_result; m_wb = 1; m_en = 0; m_wbphase = 1;
               end else if (m_age == T + 1) begin
                  m_wbdata = '0; m_wb = 1; m_err = 1; m_en = 0; m_wbphase = 1;
               end
            end
         end else if (bus.issue) begin
            if (bus.opcode >= 5'h11 && bus.opcode <= 5'h16) begin
               m_active = 1; m_age = 0; m_en = 1;
               m_op1 = bus.a_val; m_reg = bus.dest;
               m_instr = (bus.opcode == 5'h16) ? 5'h11 : bus.opcode;
               m_op2 = (bus.opcode == 5'h16) ? (bus.b_val ^ 16'h8000) : bus.b_val;
            end else begin
               m_ill = 1;
            end
         end
      end
   end

   bit cmp_on = 1'b0;
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("busy",      32'(bus.busy),      32'(m_active));
         chk("illegal",   32'(bus.illegal),   32'(m_ill));
         chk("fpu_en",    32'(bus.fpu_en),    32'(m_en));
         chk("fpu_instr", 32'(bus.fpu_instr), 32'(m_instr));
         chk("fpu_op1",   32'(bus.fpu_op1),   32'(m_op1));
         chk("fpu_op2",   32'(bus.fpu_op2),   32'(m_op2));
         chk("wb_en",     32'(bus.wb_en),     32'(m_wb));
         chk("wb_reg",    32'(bus.wb_reg),    32'(m_reg));
         chk("wb_data",   32'(bus.wb_data),   32'(m_wbdata));
         chk("err",       32'(bus.err),       32'(m_err));
      end
   end

   // ---------------- behavioural FPU ----------------
   // Leaves done untouched (possibly stale) through ARM, then drops it and
   // raises it with a random result after f_d WAIT cycles; f_d >= T times out.
   bit f_run = 0;
   int f_step = 0, f_d = 0;
   always @(posedge clk) begin
      #2;
      if (!rst_n) begin
         f_run = 0; auto_done = 1'b0;
      end else if (f_run && !bus.fpu_en) begin
         f_run = 0;
      end else if (!f_run && bus.fpu_en) begin
         f_run = 1; f_step = 0; f_d = int'($urandom_range(0, 19));
      end else if (f_run) begin
         f_step++;
         if (f_step - 1 == f_d) begin
            auto_done = 1'b1; auto_res = 16'($urandom); f_run = 0;
         end else begin
            auto_done = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic issue_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] d);
      bus.issue = 1'b1; bus.opcode = op; bus.a_val = a; bus.b_val = b; bus.dest = d;
      tick();
      bus.issue = 1'b0;
   endtask

   initial begin
      bus.issue = 1'b0; bus.opcode = '0; bus.a_val = '0; bus.b_val = '0; bus.dest = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_busy",    32'(bus.busy),    0);
      chk("rst_fpu_en",  32'(bus.fpu_en),  0);
      chk("rst_wb_en",   32'(bus.wb_en),   0);
      chk("rst_wb_data", 32'(bus.wb_data), 0);
      cmp_on = 1'b1;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // ITOF 1 -> 1.0
      issue_op(5'h13, 16'h0000, 16'h0001, 4'd3);
      chk("itof_instr", 32'(bus.fpu_instr), 32'h13);
      chk("itof_op2",   32'(bus.fpu_op2),   32'h0001);
      chk("itof_busy",  32'(bus.busy),      1);
      chk("itof_en",    32'(bus.fpu_en),    1);
      tick();
      man_done = 1'b1; man_res = 16'h3F80;
      tick();
      chk("itof_wb_en",   32'(bus.wb_en),   1);
      chk("itof_wb_reg",  32'(bus.wb_reg),  3);
      chk("itof_wb_data", 32'(bus.wb_data), 32'h3F80);
      chk("itof_err",     32'(bus.err),     0);
      chk("itof_busy_wb", 32'(bus.busy),    1);
      tick();
      chk("itof_busy_end", 32'(bus.busy),  0);
      chk("itof_wb_end",   32'(bus.wb_en), 0);

      // stale done held through ARM must not be taken
      man_res = 16'hDEAD;
      issue_op(5'h11, 16'h1111, 16'h2222, 4'd7);
      tick();
      man_done = 1'b0;
      tick(); tick(); tick();
      chk("stale_no_wb", 32'(bus.wb_en), 0);
      man_done = 1'b1; man_res = 16'h1234;
      tick();
      chk("stale_wb_en",   32'(bus.wb_en),   1);
      chk("stale_wb_data", 32'(bus.wb_data), 32'h1234);
      tick();

      // SUBF rewrite, with an issue pulse while busy that must be dropped
      man_done = 1'b0;
      issue_op(5'h16, 16'h4000, 16'h3F80, 4'd5);
      chk("subf_instr", 32'(bus.fpu_instr), 32'h11);
      chk("subf_op1",   32'(bus.fpu_op1),   32'h4000);
      chk("subf_op2",   32'(bus.fpu_op2),   32'hBF80);
      issue_op(5'h14, 16'hAAAA, 16'h5555, 4'd9);
      man_done = 1'b1; man_res = 16'h3F80;
      chk("busy_issue_instr", 32'(bus.fpu_instr), 32'h11);
      tick();
      chk("subf_wb_reg", 32'(bus.wb_reg), 5);
      tick();

      // illegal opcode
      man_done = 1'b0;
      issue_op(5'h08, 16'h0, 16'h0, 4'd1);
      chk("ill_pulse", 32'(bus.illegal), 1);
      chk("ill_busy",  32'(bus.busy),    0);
      chk("ill_en",    32'(bus.fpu_en),  0);
      tick();
      chk("ill_clear", 32'(bus.illegal), 0);

      // timeout
      issue_op(5'h14, 16'h3F80, 16'h4000, 4'd2);
      tick();
      for (int k = 2; k <= T; k++) begin
         tick();
         chk("to_wait", 32'(bus.wb_en), 0);
      end
      tick();
      chk("to_wb_en",   32'(bus.wb_en),   1);
      chk("to_err",     32'(bus.err),     1);
      chk("to_wb_data", 32'(bus.wb_data), 0);
      chk("to_fpu_en",  32'(bus.fpu_en),  0);
      tick();

      // done on the final WAIT edge wins over timeout
      issue_op(5'h15, 16'h4000, 16'h0, 4'd4);
      tick();
      for (int k = 2; k <= T; k++) tick();
      man_done = 1'b1; man_res = 16'h55AA;
      tick();
      chk("late_wb_en",   32'(bus.wb_en),   1);
      chk("late_err",     32'(bus.err),     0);
      chk("late_wb_data", 32'(bus.wb_data), 32'h55AA);
      tick();
      man_done = 1'b0;

      // reset mid-WAIT
      issue_op(5'h11, 16'h1234, 16'h4321, 4'd6);
      tick(); tick();
      #1 rst_n = 1'b0;
      #1;
      chk("rmid_en",    32'(bus.fpu_en),    0);
      chk("rmid_busy",  32'(bus.busy),      0);
      chk("rmid_instr", 32'(bus.fpu_instr), 0);
      chk("rmid_wb",    32'(bus.wb_en),     0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      issue_op(5'h12, 16'h3F80, 16'h0, 4'd8);
      tick();
      man_done = 1'b1; man_res = 16'h0001;
      tick();
      chk("post_rst_wb",   32'(bus.wb_en),   1);
      chk("post_rst_data", 32'(bus.wb_data), 32'h0001);
      tick();
      man_done = 1'b0;

      // random traffic against the behavioural FPU
      use_auto = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         bus.issue  = ($urandom_range(0, 2) != 0);
         bus.opcode = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(5'h11 + $urandom_range(0, 5));
         bus.a_val  = 16'($urandom);
         bus.b_val  = 16'($urandom);
         bus.dest   = 4'($urandom);
         tick();
      end
      bus.issue = 1'b0;
      for (int i = 0; i < 30; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Sequencer between the processor's execute stage and the floating-point unit. It captures one float instruction (ADDF, FTOI, ITOF, MULF, RECF, SUBF) with its operands and destination register. It drives the FPU's enable/opcode/operand inputs, waits for a fresh `done`, and returns the result as a one-cycle register-file write. It also stalls the processor while busy, rewrites SUBF as ADDF with a negated second operand, and aborts hung operations after a timeout.

## Interface
- TIMEOUT, 32, maximum WAIT-state cycles before abort (≥2)
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- issue  in  1  processor requests a float op this cycle
- opcode  in  5  instruction opcode (`OPxxx` encoding)
- dest  in  4  destination register number (RD field)
- a_val  in  16  value of Rd (op1)
- b_val  in  16  value of Rn (op2)
- busy  out  1  sequencer occupied; processor must hold issue
- illegal  out  1  one-cycle pulse: issued opcode not a float op
- fpu_en  out  1  FPU enable
- fpu_instr  out  5  opcode to FPU
- fpu_op1  out  16  FPU operand 1
- fpu_op2  out  16  FPU operand 2
- fpu_done  in  1  FPU completion flag (level)
- fpu_result  in  16  FPU result
- wb_en  out  1  one-cycle register write strobe
- wb_reg  out  4  register to write
- wb_data  out  16  value to write
- err  out  1  one-cycle pulse with wb_en when the op timed out

## Operation
- States: IDLE, ARM, WAIT, WB (2-bit state reg). `busy = (state != IDLE)`.
- Legal opcodes: 0x11 ADDF, 0x12 FTOI, 0x13 ITOF, 0x14 MULF, 0x15 RECF, 0x16 SUBF.
- IDLE, issue=1, legal opcode:
  - latch fpu_instr, fpu_op1=a_val, fpu_op2=b_val, wb_reg=dest.
  - SUBF is latched as fpu_instr=0x11 with fpu_op2={~b_val[15], b_val[14:0]}.
  - fpu_en<=1; go to ARM.
- IDLE, issue=1, illegal opcode: illegal<=1 for one cycle; stay IDLE; no FPU activity.
- IDLE, issue=0: hold outputs; wb_en, err, illegal <=0.
- ARM (exactly one cycle):
  - fpu_en stays 1; timeout counter <=0; go to WAIT.
  - fpu_done is ignored in ARM because its value may be stale from the previous op.
- WAIT:
  - fpu_done=1: wb_data<=fpu_result; fpu_en<=0; go to WB.
  - Otherwise, counter==TIMEOUT-1: wb_data<=0; err<=1; fpu_en<=0; go to WB.
  - Otherwise: counter++.
- WB: wb_en=1 for exactly this cycle, err as set; go to IDLE.
- Operand/opcode outputs keep their latched values until the next legal issue.
- issue while busy=1 is ignored and not queued. The processor holds the instruction until busy=0.
- Counter width: clog2(TIMEOUT)+1; it never wraps in a legal flow.

## Timing
- Reset (async, immediate): state=IDLE; busy, fpu_en, wb_en, err, illegal = 0; fpu_instr, fpu_op1, fpu_op2, wb_reg, wb_data, counter = 0.
- Reset mid-operation: abort with no write-back. The FPU sees fpu_en=0 immediately.
- All outputs are registered except busy, which is decoded from the state register.
- Edge E0 samples issue. ARM runs E0..E1 (FPU sees en at E1). WAIT starts after E1, and E2 is the first edge that samples fpu_done.
- If fpu_done is sampled high at edge En (n≥2), wb_en is high for the cycle En..En+1 and busy falls at En+1.
- Minimum issue-to-wb_en latency: 2 cycles after E0 (FPU single-cycle completion). Issue-to-next-accept: 4 edges minimum.
- Timeout: err/wb_en are asserted TIMEOUT cycles after entering WAIT.
- fpu_done high at the same edge the counter hits its limit: done wins, so the result is written and err=0.

## Test plan
- ITOF, issue with opcode=0x13, b_val=0x0001, dest=3, real FPU → fpu_instr=0x13, fpu_op2=0x0001; then wb_en one cycle with wb_reg=3, wb_data=0x3F80, err=0; busy high from E0 until WB ends.
- SUBF rewrite, opcode=0x16, a_val=0x4000, b_val=0x3F80 → fpu_instr=0x11, fpu_op1=0x4000, fpu_op2=0xBF80.
- Illegal opcode, opcode=0x08 with issue=1 → illegal pulse one cycle; busy, fpu_en, wb_en stay 0.
- Stale done, model FPU holding done=1 through ARM and dropping it at E1, then raising it 3 cycles later with result 0x1234 → write-back uses 0x1234, not the stale value.
- Timeout, TIMEOUT=16 with model done stuck at 0 → after 16 WAIT cycles, wb_en=1, err=1, wb_data=0x0000, fpu_en=0; done rising on the 16th edge instead → err=0.
- Reset and busy issue:
  - rst_n low mid-WAIT → all outputs 0 at once, no wb_en.
  - issue pulsed during busy → ignored; the next op completes normally after return to IDLE.
